// File: rtl/avr_ifetch_pkg.sv
// rtl/avr_ifetch_pkg.sv - fetch-state encoding and AVR two-word opcode mask/match constants
package avr_ifetch_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_W0    = 2'd1,
        ST_W1    = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    localparam logic [15:0] LDS_STS_MASK   = 16'hFC0F;
    localparam logic [15:0] LDS_STS_MATCH  = 16'h9000;
    localparam logic [15:0] JMP_CALL_MASK  = 16'hFE0C;
    localparam logic [15:0] JMP_CALL_MATCH = 16'h940C;

endpackage

// File: rtl/avr_ifetch_if.sv
// rtl/avr_ifetch_if.sv - flash read port and decoder handshake bundle for the fetch stage
interface avr_ifetch_if #(
    parameter int FLASH_WIDTH = 10
);
    logic                   mem_ce;
    logic [FLASH_WIDTH-1:0] mem_a;
    logic [15:0]            mem_d;
    logic                   insn_valid;
    logic                   insn_ready;
    logic [31:0]            insn;
    logic [FLASH_WIDTH-1:0] insn_pc;
    logic                   insn_two_word;

    modport master (
        output mem_ce, mem_a, insn_valid, insn, insn_pc, insn_two_word,
        input  mem_d, insn_ready
    );

    modport slave (
        input  mem_ce, mem_a, insn_valid, insn, insn_pc, insn_two_word,
        output mem_d, insn_ready
    );
endinterface

// File: rtl/avr_insn_len.sv
// rtl/avr_insn_len.sv - flags LDS/STS/JMP/CALL first words as two-word instructions
module avr_insn_len
    import avr_ifetch_pkg::*;
(
    input  logic [15:0] i_word,
    output logic        o_two_word
);

    assign o_two_word = ((i_word & LDS_STS_MASK)  == LDS_STS_MATCH) ||
                        ((i_word & JMP_CALL_MASK) == JMP_CALL_MATCH);

endmodule

// File: rtl/avr_ifetch.sv
// rtl/avr_ifetch.sv - AVR fetch stage; AVR_IFETCH_SKIP_EN adds the skip input for CPSE/SBRx/SBIx
module avr_ifetch
    import avr_ifetch_pkg::*;
#(
    parameter int          FLASH_WIDTH  = 10,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pc_load,
    input  logic [FLASH_WIDTH-1:0] pc_load_addr,
`ifdef AVR_IFETCH_SKIP_EN
    input  logic                   skip,
`endif
    avr_ifetch_if.master           bus
);

    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_W0    = ST_W0;
    localparam logic [1:0] S_W1    = ST_W1;
    localparam logic [1:0] S_HOLD  = ST_HOLD;

    logic [1:0]             r_state;
    logic [FLASH_WIDTH-1:0] r_fpc;
    logic [FLASH_WIDTH-1:0] r_insn_pc;
    logic [31:0]            r_insn;
    logic                   r_two_word;
    logic                   r_skip_pend;

    logic                   w_w0_two;
    logic                   w_skip_in;
    logic                   w_mem_ce;
    logic [FLASH_WIDTH-1:0] w_mem_a;
    logic [FLASH_WIDTH-1:0] w_fpc_p1;
    logic [FLASH_WIDTH-1:0] w_fpc_p2;

`ifdef AVR_IFETCH_SKIP_EN
    assign w_skip_in = skip;
`else
    assign w_skip_in = 1'b0;
`endif

    avr_insn_len u_len (
        .i_word     (bus.mem_d),
        .o_two_word (w_w0_two)
    );

    assign w_fpc_p1 = r_fpc + FLASH_WIDTH'(1);
    assign w_fpc_p2 = r_fpc + FLASH_WIDTH'(2);

    // Flash requests are combinational so a transfer or redirect issues in the same cycle.
    always_comb begin
        w_mem_ce = 1'b0;
        w_mem_a  = '0;
        if (!rst_n) begin
            w_mem_ce = 1'b0;
        end else if (pc_load) begin
            w_mem_ce = 1'b1;
            w_mem_a  = pc_load_addr;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    w_mem_ce = 1'b1;
                    w_mem_a  = r_fpc;
                end
                S_W0: begin
                    if (w_w0_two) begin
                        w_mem_ce = 1'b1;
                        w_mem_a  = w_fpc_p1;
                    end
                end
                S_HOLD: begin
                    if (bus.insn_ready) begin
                        w_mem_ce = 1'b1;
                        w_mem_a  = r_fpc;
                    end
                end
                default: w_mem_ce = 1'b0;
            endcase
        end
    end

    // A pending skip completes the fetch normally but re-enters ISSUE instead of HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_ISSUE;
            r_fpc       <= FLASH_WIDTH'(RESET_VECTOR);
            r_insn_pc   <= '0;
            r_insn      <= '0;
            r_two_word  <= 1'b0;
            r_skip_pend <= 1'b0;
        end else if (pc_load) begin
            r_state     <= S_W0;
            r_fpc       <= pc_load_addr;
            r_skip_pend <= 1'b0;
        end else begin
            case (r_state)
                S_ISSUE: r_state <= S_W0;
                S_W0: begin
                    r_insn     <= {16'h0000, bus.mem_d};
                    r_insn_pc  <= r_fpc;
                    r_two_word <= w_w0_two;
                    if (w_w0_two) begin
                        r_state <= S_W1;
                    end else begin
                        r_fpc       <= w_fpc_p1;
                        r_state     <= r_skip_pend ? S_ISSUE : S_HOLD;
                        r_skip_pend <= 1'b0;
                    end
                end
                S_W1: begin
                    r_insn[31:16] <= bus.mem_d;
                    r_fpc         <= w_fpc_p2;
                    r_state       <= r_skip_pend ? S_ISSUE : S_HOLD;
                    r_skip_pend   <= 1'b0;
                end
                S_HOLD: begin
                    if (bus.insn_ready) begin
                        r_state     <= S_W0;
                        r_skip_pend <= w_skip_in;
                    end
                end
                default: r_state <= S_ISSUE;
            endcase
        end
    end

    assign bus.mem_ce        = w_mem_ce;
    assign bus.mem_a         = w_mem_a;
    assign bus.insn_valid    = rst_n && (r_state == S_HOLD);
    assign bus.insn          = r_insn;
    assign bus.insn_pc       = r_insn_pc;
    assign bus.insn_two_word = r_two_word;

endmodule

// File: tb/tb_avr_ifetch.sv
// tb/tb_avr_ifetch.sv - scoreboard bench for avr_ifetch with a one-cycle-latency flash model
module tb_avr_ifetch;

    localparam int FW = 10;

    typedef struct packed {
        logic [31:0]   insn;
        logic [FW-1:0] pc;
        logic          tw;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pc_load = 1'b0;
    logic [FW-1:0] pc_load_addr = '0;
`ifdef AVR_IFETCH_SKIP_EN
    logic          skip = 1'b0;
`endif

    logic [15:0] flash [0:(1<<FW)-1];
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_xfer = 0;
    int          n_pushed = 0;

    avr_ifetch_if #(.FLASH_WIDTH(FW)) bus ();

    avr_ifetch #(.FLASH_WIDTH(FW), .RESET_VECTOR(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
`ifdef AVR_IFETCH_SKIP_EN
        .skip         (skip),
`endif
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_d <= bus.mem_ce ? flash[bus.mem_a] : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] insn, input int pc, input logic tw);
        exp_t e;
        e.insn = insn;
        e.pc   = FW'(pc);
        e.tw   = tw;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic wait_xfer(input int n);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (n_xfer >= n) break;
        end
        check("xfer_count", 32'(n_xfer), 32'(n));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.insn_valid) break;
        end
        check("valid_seen", 32'(bus.insn_valid), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", 32'(bus.insn_valid), 32'd0);
        check("rst_mem_ce", 32'(bus.mem_ce), 32'd0);
        check("rst_mem_a", 32'(bus.mem_a), 32'd0);
        check("rst_insn", bus.insn, 32'd0);
        check("rst_insn_pc", 32'(bus.insn_pc), 32'd0);
        check("rst_two_word", 32'(bus.insn_two_word), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.insn_valid && bus.insn_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_xfer: got pc %h, expected no transfer", bus.insn_pc);
            end else begin
                e = exp_q.pop_front();
                check("xfer_insn", bus.insn, e.insn);
                check("xfer_pc", 32'(bus.insn_pc), 32'(e.pc));
                check("xfer_two_word", 32'(bus.insn_two_word), 32'(e.tw));
            end
            n_xfer++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        for (int i = 0; i < (1 << FW); i++) flash[i] = 16'h0000;
        flash[1]     = 16'hE0A5;
        flash[4]     = 16'h940C;  flash[5]  = 16'h0123;
        flash[6]     = 16'h9100;  flash[7]  = 16'h0456;
        flash[8]     = 16'h1000;
        flash[9]     = 16'h9200;  flash[10] = 16'h0789;
        flash[11]    = 16'hE0B6;
        flash[12]    = 16'h9000;  flash[13] = 16'h0ABC;
        flash[10'h3FF] = 16'h940E;

        bus.insn_ready = 1'b1;
        push(32'h0000_0000, 0, 1'b0);
        push(32'h0000_E0A5, 1, 1'b0);
        push(32'h0000_0000, 2, 1'b0);
        push(32'h0000_0000, 3, 1'b0);
        push(32'h0123_940C, 4, 1'b1);
        push(32'h0456_9100, 6, 1'b1);
        push(32'h0000_1000, 8, 1'b0);
`ifndef AVR_IFETCH_SKIP_EN
        push(32'h0789_9200, 9, 1'b1);
`endif
        push(32'h0000_E0B6, 11, 1'b0);
        push(32'h0000_940E, 10'h3FF, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();

        // The edge just before rst_n rises is edge 1.
        @(posedge clk);
        #1 rst_n = 1'b1;
        edges = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.insn_valid) break;
        end
        check("first_valid_edge", 32'(edges), 32'd3);
        @(posedge clk);
        #1 check("b2b_gap_valid", 32'(bus.insn_valid), 32'd0);
        @(posedge clk);
        #1 check("b2b_second_valid", 32'(bus.insn_valid), 32'd1);
        check("b2b_second_pc", 32'(bus.insn_pc), 32'd1);

        wait_xfer(6);
        bus.insn_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.insn_valid), 32'd1);
            check("stall_mem_ce", 32'(bus.mem_ce), 32'd0);
            check("stall_insn", bus.insn, 32'h0000_1000);
            check("stall_pc", 32'(bus.insn_pc), 32'd8);
        end
        @(posedge clk);
        #1 bus.insn_ready = 1'b1;
`ifdef AVR_IFETCH_SKIP_EN
        skip = 1'b1;
`endif
        @(posedge clk);
`ifdef AVR_IFETCH_SKIP_EN
        #1 skip = 1'b0;
`endif

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.mem_ce && bus.mem_a == FW'(13)) break;
        end
        check("w1_fetch_seen", 32'(bus.mem_a), 32'd13);
        @(posedge clk);
        #1 pc_load = 1'b1;
        pc_load_addr = 10'h3FF;
        @(negedge clk);
        check("redir_mem_ce", 32'(bus.mem_ce), 32'd1);
        check("redir_mem_a", 32'(bus.mem_a), 32'h3FF);
        check("redir_valid", 32'(bus.insn_valid), 32'd0);
        @(posedge clk);
        #1 pc_load = 1'b0;
        @(negedge clk);
        check("wrap_mem_ce", 32'(bus.mem_ce), 32'd1);
        check("wrap_mem_a", 32'(bus.mem_a), 32'd0);

        wait_xfer(n_pushed);
        bus.insn_ready = 1'b0;
        wait_valid();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        #1;
        check("refetch_mem_ce", 32'(bus.mem_ce), 32'd1);
        check("refetch_mem_a", 32'(bus.mem_a), 32'd0);
        push(32'h0000_0000, 0, 1'b0);
        push(32'h0000_E0A5, 1, 1'b0);
        bus.insn_ready = 1'b1;
        wait_xfer(n_pushed);
        bus.insn_ready = 1'b0;
        repeat (5) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
